mux_rr_arb: RTL
===============

# mux_rr_arb

Parametrised N-channel registered multiplexer with valid/ready handshaking, selectable fixed-select or round-robin arbitration, and a one-beat output register. It generalises the team's combinational 4:1 data-flow mux into a streaming channel merger. It sits between several producer streams and a single consumer, such as a shared bus or an output port.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (≥1)
- NCH, 4, number of input channels (2..16)
- SELW, $clog2(NCH), select/channel-index width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel valid
- in_ready  output  NCH  per-channel ready (combinational)
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel index used in fixed mode
- out_data  output  WIDTH  registered data
- out_ch  output  SELW  registered source channel of out_data
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready
- in_last  input  NCH  end-of-packet marker; present only with MUX_RR_LOCK_EN

## Operation
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=0, lock state IDLE.
- Load enable: `ld = !out_valid || out_ready`.
- Grant, fixed mode: g = sel if in_valid[sel]. Otherwise there is no grant. sel values ≥ NCH give no grant.
- Grant, round-robin mode: g = first k with in_valid[k]=1, scanning rr_ptr, rr_ptr+1, … modulo NCH.
- in_ready[k] = ld && grant valid && k==g. All other bits are 0. At most one in_ready bit is high per cycle.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. On the next edge: out_data←in_data[g], out_ch←g, out_valid←1.
- If ld=1 and there is no grant, out_valid←0 on the next edge. out_data and out_ch hold their values.
- Round-robin pointer: after an accepted transfer in RR mode, rr_ptr←(g+1) mod NCH. Wrap from NCH-1 to 0. It is not updated in fixed mode or when no transfer occurs.
- Output stall: if out_valid && !out_ready, all output registers hold and in_ready is all zeros.
- mode and sel are sampled every cycle. A change affects the arbitration of that same cycle. The held output beat is never altered.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle while out_ready=1 and a grant exists.
- in_ready depends combinationally on out_ready, in_valid, mode and sel. It never depends combinationally on in_data.
- Reset asserted mid-operation: outputs return to their reset values immediately (asynchronous) and any held beat is discarded. The first transfer is possible on the first edge after rst deasserts.

## Configuration
- MUX_RR_LOCK_EN defined:
  - The in_last port exists.
  - Two-state FSM:
    - IDLE→LOCKED on an accepted transfer with in_last[g]=0. The locked channel L is recorded.
    - LOCKED→IDLE on an accepted transfer from L with in_last[L]=1.
  - While LOCKED, the grant is L only, regardless of mode, sel or the other valids. If L is not valid, there is no grant.
  - rr_ptr updates only on the LOCKED→IDLE transfer, or on a single-beat packet accepted in IDLE.
  - Reset puts the FSM in IDLE.
- MUX_RR_LOCK_EN undefined:
  - There is no in_last port and no FSM.
  - Arbitration is per beat.

## Test plan
- Fixed mode, sel=2, in_valid=4'b1111, data 0x10/0x11/0x12/0x13, out_ready=1 → in_ready=4'b0100 each cycle; out_data=0x12, out_ch=2 one cycle later, with continuous out_valid.
- RR mode, all valid, out_ready=1 → out_ch sequence 0,1,2,3,0,… (wrap); in_ready rotates one-hot.
- RR mode, in_valid=4'b1010, rr_ptr=2 → grant 3, then 1, then 3; channels 0 and 2 are never granted.
- Backpressure: beat 0xAA held, out_ready=0 for 3 cycles → out_data stays 0xAA and out_valid stays 1, in_ready=0. When out_ready rises, the next beat is accepted that same cycle.
- Reset asserted mid-stream with out_valid=1 → out_valid, out_data and out_ch go to 0 without waiting for a clock edge; after release the RR order restarts at channel 0.
- MUX_RR_LOCK_EN defined: channel 1 sends 3 beats with in_last=0,0,1 while channel 0 is also valid → out_ch=1,1,1, then 0.

Source files
------------

// File: rtl/mux_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_arb
//  Purpose  : N-channel streaming merger with valid/ready handshaking,
//             fixed-select or round-robin arbitration and a one-beat
//             registered output stage.
//  Options  : MUX_RR_LOCK_EN - adds in_last and a packet lock so that a
//             multi-beat packet is never interleaved with other channels.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arb #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
`ifdef MUX_RR_LOCK_EN
  input  logic [NCH-1:0]       in_last,
`endif
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic             r_out_valid;
  logic [SELW-1:0]  r_rr_ptr;

  logic             w_ld;
  logic             w_fix_vld;
  logic             w_rr_vld;
  logic [SELW-1:0]  w_rr_g;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_g;
  logic             w_xfer;
  logic             w_last_g;
  logic             w_rr_upd;
  logic [WIDTH-1:0] w_mux_data;

  // The output register can take a new beat when empty or being drained.
  assign w_ld   = !r_out_valid || out_ready;
  assign w_xfer = w_ld && w_gnt_vld;

  // Candidate grants for both modes; sel values beyond NCH-1 match nothing.
  always_comb begin
    logic [SELW:0] v_sum;
    w_fix_vld = 1'b0;
    w_rr_vld  = 1'b0;
    w_rr_g    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (in_valid[k] && (sel == k[SELW-1:0])) w_fix_vld = 1'b1;
    end
    for (int i = 0; i < NCH; i++) begin
      v_sum = {1'b0, r_rr_ptr} + i[SELW:0];
      if (v_sum >= (SELW+1)'(NCH)) v_sum = v_sum - (SELW+1)'(NCH);
      if (!w_rr_vld && in_valid[v_sum[SELW-1:0]]) begin
        w_rr_vld = 1'b1;
        w_rr_g   = v_sum[SELW-1:0];
      end
    end
  end

`ifdef MUX_RR_LOCK_EN
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [SELW-1:0] r_lock_ch;
  logic            w_lock_vld;

  // Valid of the locked channel.
  always_comb begin
    w_lock_vld = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (r_lock_ch == k[SELW-1:0]) w_lock_vld = in_valid[k];
    end
  end

  // Final grant: a locked packet owns the output regardless of mode/sel.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_g       = '0;
    if (r_state == ST_LOCKED) begin
      w_gnt_vld = w_lock_vld;
      w_g       = r_lock_ch;
    end else if (mode) begin
      w_gnt_vld = w_rr_vld;
      w_g       = w_rr_g;
    end else begin
      w_gnt_vld = w_fix_vld;
      w_g       = sel;
    end
  end

  // End-of-packet flag of the granted channel.
  always_comb begin
    w_last_g = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (w_g == k[SELW-1:0]) w_last_g = in_last[k];
    end
  end

  // Lock FSM next state: enter on a non-final beat, leave on the final one.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_xfer && !w_last_g) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_xfer &&  w_last_g) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Remember which channel opened the packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         r_lock_ch <= '0;
    else if (r_state == ST_IDLE && w_xfer && !w_last_g) r_lock_ch <= w_g;
  end

  // Pointer advances only when a whole packet has completed.
  assign w_rr_upd = w_xfer && mode && w_last_g;
`else
  // Final grant, arbitrated independently on every beat.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_g       = '0;
    if (mode) begin
      w_gnt_vld = w_rr_vld;
      w_g       = w_rr_g;
    end else begin
      w_gnt_vld = w_fix_vld;
      w_g       = sel;
    end
  end

  assign w_last_g = 1'b1;
  assign w_rr_upd = w_xfer && mode && w_last_g;
`endif

  // One-hot ready toward the granted producer; never depends on in_data.
  always_comb begin
    in_ready = '0;
    if (w_xfer) in_ready[w_g] = 1'b1;
  end

  // Data path select of the granted channel.
  always_comb begin
    w_mux_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_g == k[SELW-1:0]) w_mux_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Output beat register: load on transfer, empty when loading with no grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_ld) begin
      if (w_gnt_vld) begin
        r_out_data  <= w_mux_data;
        r_out_ch    <= w_g;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer: one past the last served channel, with wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_rr_ptr <= '0;
    else if (w_rr_upd) r_rr_ptr <= (w_g == SELW'(NCH-1)) ? '0 : w_g + SELW'(1);
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire
